// File: rtl/pc_ctrl.sv
// -----------------------------------------------------------------------------
// pc_ctrl : program counter and branch-resolution stage.
//
// Sits directly downstream of the cmp comparator. Owns the architectural PC,
// issues sequential fetch addresses, redirects on taken branches and jumps, and
// traps on misaligned taken targets, holding until trap_ack.
//
// Optional feature macro: PC_CTRL_STATS_EN (adds the stat_* counter outputs).
//
// Parameters
//   XLEN      datapath / PC width
//   RESET_PC  PC value loaded on reset and on trap acknowledge
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   stall      in   hold the fetch PC (downstream not ready)
//   ex_valid   in   execute stage holds a valid instruction
//   ex_branch  in   conditional branch in execute
//   ex_jal     in   JAL in execute
//   ex_jalr    in   JALR in execute
//   cmp_q      in   comparator result for the branch (1 = condition true)
//   ex_pc      in   PC of the execute-stage instruction
//   ex_imm     in   sign-extended immediate
//   ex_rs1     in   rs1 value (JALR base)
//   trap_ack   in   leave the trap state
//   pc         out  current fetch address (registered)
//   pc_valid   out  pc is a valid fetch request (registered)
//   flush      out  one-cycle kill of younger instructions (registered)
//   link       out  ex_pc + 4, combinational, rd writeback for JAL/JALR
//   trap       out  misaligned-target trap pending (registered)
//   trap_pc    out  ex_pc of the faulting instruction (registered)
//   stat_branches / stat_taken / stat_redirects (PC_CTRL_STATS_EN only)
//              out  saturating event counters (registered)
// -----------------------------------------------------------------------------
module pc_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic            cmp_q,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            trap_ack,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic [XLEN-1:0] link,
  output logic            trap,
  output logic [XLEN-1:0] trap_pc
`ifdef PC_CTRL_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken,
  output logic [31:0]     stat_redirects
`endif
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            flush_q, flush_d;
  logic            trap_q, trap_d;

  logic            jalr_sel;
  logic            take;
  logic            aligned;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;

  // Redirect resolution; JAL wins over JALR when both decode bits are set.
  assign jalr_sel = ex_jalr & ~ex_jal;
  assign jalr_sum = ex_rs1 + ex_imm;
  assign target   = jalr_sel ? (jalr_sum & ~XLEN'(1)) : (ex_pc + ex_imm);
  assign take     = ex_valid & (ex_jal | ex_jalr | (ex_branch & cmp_q));
  assign aligned  = (target[1:0] == 2'b00);

  assign link = ex_pc + PC_STEP;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      trap_q     <= 1'b0;
      trap_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
      trap_q     <= trap_d;
      trap_pc_q  <= trap_pc_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    flush_d   = 1'b0;
    trap_d    = trap_q;
    trap_pc_d = trap_pc_q;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        // A redirect overrides both sequential advance and stall.
        if (take) begin
          flush_d = 1'b1;
          if (aligned) begin
            pc_d = target;
          end else begin
            state_d   = TRAP;
            trap_d    = 1'b1;
            trap_pc_d = ex_pc;
          end
        end else if (!stall) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      TRAP: begin
        if (trap_ack) begin
          state_d = RUN;
          trap_d  = 1'b0;
          pc_d    = RESET_PC;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    // Fetch requests are only valid while running.
    pc_valid_d = (state_d == RUN);
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign flush    = flush_q;
  assign trap     = trap_q;
  assign trap_pc  = trap_pc_q;

`ifdef PC_CTRL_STATS_EN
  localparam int unsigned STAT_W = 32;

  logic [STAT_W-1:0] stat_br_q, stat_tk_q, stat_rd_q;
  logic              cnt_branch, cnt_taken, cnt_redir;

  // Execute inputs are only acted on in RUN, so events are counted only there.
  assign cnt_branch = (state_q == RUN) & ex_valid & ex_branch & ~ex_jal & ~ex_jalr;
  assign cnt_taken  = cnt_branch & cmp_q;
  assign cnt_redir  = (state_q == RUN) & take & aligned;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_tk_q <= '0;
      stat_rd_q <= '0;
    end else begin
      if (cnt_branch && (stat_br_q != '1)) stat_br_q <= stat_br_q + STAT_W'(1);
      if (cnt_taken  && (stat_tk_q != '1)) stat_tk_q <= stat_tk_q + STAT_W'(1);
      if (cnt_redir  && (stat_rd_q != '1)) stat_rd_q <= stat_rd_q + STAT_W'(1);
    end
  end

  assign stat_branches  = stat_br_q;
  assign stat_taken     = stat_tk_q;
  assign stat_redirects = stat_rd_q;
`endif

endmodule
